// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer
//   Multi-frame run controller for the lane-detection CNN pipeline.
//   It starts the feature extractor and then the FC layer for each frame.
//   Each FC result is presented on a valid/ready output together with its
//   frame index. A run ends with a run_done pulse and a hold period in DONE.
//
//   Optional build macro CNN_SEQ_WATCHDOG_EN:
//     defined     - a per-stage watchdog bounds FEATURE and WAIT_FC to
//                   PROC_TIMEOUT cycles. On expiry it produces a zero result
//                   tagged result_timeout and bumps timeout_count.
//     not defined - FEATURE and WAIT_FC wait indefinitely. result_timeout
//                   and timeout_count stay 0.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   start_signal/frame_count run request and frames per run (IDLE only)
//   abort                    cancel the current run, back to IDLE
//   fe_start, buf_full       feature extractor start pulse / buffer full level
//   fc_start                 FC layer start pulse
//   fc_result_valid/_data    FC result strobe and value
//   result_valid/_ready      output handshake
//   result_data/_frame/_timeout  latched result, its frame index, watchdog tag
//   run_done                 one-cycle pulse on entry to DONE
//   cnn_busy                 high whenever not IDLE
//   timeout_count            saturating watchdog event count since reset
module cnn_frame_sequencer #(
    parameter int RESULT_W     = 48,
    parameter int TIMER_W      = 16,
    parameter int PROC_TIMEOUT = 50000,
    parameter int DONE_HOLD    = 1000,
    parameter int FRAME_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_signal,
    input  logic [FRAME_W-1:0]         frame_count,
    input  logic                       abort,
    output logic                       fe_start,
    input  logic                       buf_full,
    output logic                       fc_start,
    input  logic                       fc_result_valid,
    input  logic signed [RESULT_W-1:0] fc_result_data,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic signed [RESULT_W-1:0] result_data,
    output logic [FRAME_W-1:0]         result_frame,
    output logic                       result_timeout,
    output logic                       run_done,
    output logic                       cnn_busy,
    output logic [FRAME_W-1:0]         timeout_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEATURE,
        S_WAIT_FC,
        S_OUTPUT,
        S_DONE
    } state_t;

`ifdef CNN_SEQ_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam logic [TIMER_W-1:0] PROC_LAST = TIMER_W'(PROC_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] DONE_LAST = TIMER_W'(DONE_HOLD - 1);

    state_t               state, state_nxt;
    logic [TIMER_W-1:0]   timer;
    logic                 buf_full_d1;
    logic [FRAME_W-1:0]   frames_total;
    logic [FRAME_W-1:0]   frame_idx;
    logic                 buf_rise;
    logic                 handshake;
    logic                 last_frame;
    logic                 wd_expired;
    logic                 fc_take;
    logic                 wd_fire;

    function automatic logic [TIMER_W-1:0] timer_sat_inc(input logic [TIMER_W-1:0] t);
        return (t == {TIMER_W{1'b1}}) ? t : t + TIMER_W'(1);
    endfunction

    function automatic logic [FRAME_W-1:0] count_sat_inc(input logic [FRAME_W-1:0] c);
        return (c == {FRAME_W{1'b1}}) ? c : c + FRAME_W'(1);
    endfunction

    assign buf_rise   = buf_full & ~buf_full_d1;
    assign handshake  = result_valid & result_ready;
    assign last_frame = (frame_idx == frames_total - FRAME_W'(1));
    // A build without the watchdog reduces this to a constant 0, which
    // keeps FEATURE/WAIT_FC waiting forever and the timeout outputs at 0.
    assign wd_expired = WD_EN && (timer == PROC_LAST);
    assign cnn_busy   = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        fc_take   = 1'b0;
        wd_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_signal && frame_count != '0) state_nxt = S_FEATURE;
            end
            S_FEATURE: begin
                // A real exit event takes precedence over an expiring watchdog.
                if (buf_rise) begin
                    state_nxt = S_WAIT_FC;
                end else if (wd_expired) begin
                    state_nxt = S_OUTPUT;
                    wd_fire   = 1'b1;
                end
            end
            S_WAIT_FC: begin
                if (fc_result_valid) begin
                    state_nxt = S_OUTPUT;
                    fc_take   = 1'b1;
                end else if (wd_expired) begin
                    state_nxt = S_OUTPUT;
                    wd_fire   = 1'b1;
                end
            end
            S_OUTPUT: begin
                if (handshake) state_nxt = last_frame ? S_DONE : S_FEATURE;
            end
            S_DONE: begin
                if (timer == DONE_LAST) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
            fc_take   = 1'b0;
            wd_fire   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            timer          <= '0;
            buf_full_d1    <= 1'b0;
            frames_total   <= '0;
            frame_idx      <= '0;
            fe_start       <= 1'b0;
            fc_start       <= 1'b0;
            result_valid   <= 1'b0;
            result_data    <= '0;
            result_frame   <= '0;
            result_timeout <= 1'b0;
            run_done       <= 1'b0;
            timeout_count  <= '0;
        end else begin
            state       <= state_nxt;
            buf_full_d1 <= buf_full;
            timer       <= (state_nxt != state) ? '0 : timer_sat_inc(timer);

            // Strobes are registered from the upcoming state, so they line up
            // with the first cycle spent in the state they announce.
            fe_start     <= (state_nxt == S_FEATURE) && (state != S_FEATURE);
            fc_start     <= (state_nxt == S_WAIT_FC) && (state != S_WAIT_FC);
            run_done     <= (state_nxt == S_DONE) && (state != S_DONE);
            result_valid <= (state_nxt == S_OUTPUT);

            if (state == S_IDLE && state_nxt == S_FEATURE) begin
                frames_total <= frame_count;
                frame_idx    <= '0;
            end
            if (state == S_OUTPUT && state_nxt == S_FEATURE) begin
                frame_idx <= frame_idx + FRAME_W'(1);
            end

            if (fc_take) begin
                result_data    <= fc_result_data;
                result_frame   <= frame_idx;
                result_timeout <= 1'b0;
            end else if (wd_fire) begin
                result_data    <= '0;
                result_frame   <= frame_idx;
                result_timeout <= 1'b1;
                timeout_count  <= count_sat_inc(timeout_count);
            end
        end
    end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer
//   Self-checking bench for cnn_frame_sequencer. It uses a table of run
//   descriptions, randomized runs built from an expected-result list, and
//   hand-written sequences for the watchdog, abort and reset corners.
//   Set CNN_SEQ_WATCHDOG_EN consistently with the design build.
module tb_cnn_frame_sequencer;

    localparam int RESULT_W     = 48;
    localparam int TIMER_W      = 16;
    localparam int PROC_TIMEOUT = 100;
    localparam int DONE_HOLD    = 8;
    localparam int FRAME_W      = 8;

    logic                       clk;
    logic                       rst;
    logic                       start_signal;
    logic [FRAME_W-1:0]         frame_count;
    logic                       abort;
    logic                       fe_start;
    logic                       buf_full;
    logic                       fc_start;
    logic                       fc_result_valid;
    logic signed [RESULT_W-1:0] fc_result_data;
    logic                       result_valid;
    logic                       result_ready;
    logic signed [RESULT_W-1:0] result_data;
    logic [FRAME_W-1:0]         result_frame;
    logic                       result_timeout;
    logic                       run_done;
    logic                       cnn_busy;
    logic [FRAME_W-1:0]         timeout_count;

    cnn_frame_sequencer #(
        .RESULT_W    (RESULT_W),
        .TIMER_W     (TIMER_W),
        .PROC_TIMEOUT(PROC_TIMEOUT),
        .DONE_HOLD   (DONE_HOLD),
        .FRAME_W     (FRAME_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_signal   (start_signal),
        .frame_count    (frame_count),
        .abort          (abort),
        .fe_start       (fe_start),
        .buf_full       (buf_full),
        .fc_start       (fc_start),
        .fc_result_valid(fc_result_valid),
        .fc_result_data (fc_result_data),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_data    (result_data),
        .result_frame   (result_frame),
        .result_timeout (result_timeout),
        .run_done       (run_done),
        .cnn_busy       (cnn_busy),
        .timeout_count  (timeout_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    int fe_cnt = 0;
    int fc_cnt = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (fe_start === 1'b1) fe_cnt <= fe_cnt + 1;
        if (fc_start === 1'b1) fc_cnt <= fc_cnt + 1;
        if (run_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    int vec_cnt = 0;
    int miss_cnt = 0;
    int tc_exp = 0;

    typedef struct {
        int                         frames;
        int                         bd;
        int                         fd;
        int                         rd;
        logic signed [RESULT_W-1:0] data;
        int                         exp_fe;
        int                         exp_done;
    } vec_t;

    vec_t tbl[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic start_run(input int n);
        start_signal = 1'b1;
        frame_count  = FRAME_W'(n);
        tick();
        start_signal = 1'b0;
        check("start_accept", {fe_start, cnn_busy}, {1'b1, 1'b1});
    endtask

    // Entered in a FEATURE cycle; leaves right after the handshake edge.
    task automatic do_frame(input int idx, input bit last, input int bd, input int fd,
                            input int rd, input logic signed [RESULT_W-1:0] data);
        for (int i = 0; i < bd; i++) begin
            start_signal    = 1'($urandom_range(0, 1));
            frame_count     = FRAME_W'($urandom());
            fc_result_valid = 1'($urandom_range(0, 1));
            fc_result_data  = RESULT_W'({$urandom(), $urandom()});
            tick();
        end
        start_signal    = 1'b0;
        fc_result_valid = 1'b0;
        buf_full        = 1'b1;
        tick();
        buf_full = 1'b0;
        check("fc_start", {fc_start, fe_start}, {1'b1, 1'b0});
        for (int i = 0; i < fd; i++) tick();
        check("wait_fc_quiet", {fc_start, result_valid}, 2'b00);
        fc_result_valid = 1'b1;
        fc_result_data  = data;
        tick();
        fc_result_valid = 1'b0;
        fc_result_data  = RESULT_W'({$urandom(), $urandom()});
        check("result", {result_valid, result_timeout, result_frame, result_data},
              {1'b1, 1'b0, FRAME_W'(idx), data});
        for (int i = 0; i < rd; i++) begin
            buf_full        = 1'($urandom_range(0, 1));
            fc_result_valid = 1'($urandom_range(0, 1));
            tick();
            check("result_hold", {result_valid, fe_start, result_frame, result_data},
                  {1'b1, 1'b0, FRAME_W'(idx), data});
        end
        buf_full        = 1'b0;
        fc_result_valid = 1'b0;
        result_ready    = 1'b1;
        tick();
        result_ready = 1'b0;
        check("after_handshake", {result_valid, run_done, fe_start}, {1'b0, last, !last});
    endtask

    // Entered on the run_done cycle.
    task automatic done_hold();
        for (int i = 0; i < DONE_HOLD - 1; i++) tick();
        check("done_hold", {cnn_busy, run_done}, {1'b1, 1'b0});
        tick();
        check("done_to_idle", {cnn_busy, result_valid}, {1'b0, 1'b0});
    endtask

    initial begin
        int s_fe, s_fc, s_done, n;
        logic signed [RESULT_W-1:0] exp_q[$];

        rst             = 1'b0;
        start_signal    = 1'b0;
        frame_count     = '0;
        abort           = 1'b0;
        buf_full        = 1'b0;
        fc_result_valid = 1'b0;
        fc_result_data  = '0;
        result_ready    = 1'b0;

        tbl[0] = '{1, 20, 5, 0, 48'sh000000001234, 1, 1};
        tbl[1] = '{3, 3, 2, 10, 48'sh800000000001, 3, 1};
        tbl[2] = '{2, 0, 1, 1, 48'shFFFFFFFFFFFF, 2, 1};

        tick();
        tick();
        check("reset_state", {fe_start, fc_start, result_valid, result_data, result_frame,
              result_timeout, run_done, cnn_busy, timeout_count}, '0);
        rst = 1'b1;
        tick();
        check("idle_after_reset", {cnn_busy, fe_start}, 2'b00);

        // Table-driven runs.
        for (int t = 0; t < 3; t++) begin
            s_fe = fe_cnt; s_fc = fc_cnt; s_done = done_cnt;
            start_run(tbl[t].frames);
            for (int i = 0; i < tbl[t].frames; i++)
                do_frame(i, i == tbl[t].frames - 1, tbl[t].bd, tbl[t].fd,
                         (i == 1) ? tbl[t].rd : 0, tbl[t].data + RESULT_W'(i));
            done_hold();
            check("fe_pulses", 80'(fe_cnt - s_fe), 80'(tbl[t].exp_fe));
            check("fc_pulses", 80'(fc_cnt - s_fc), 80'(tbl[t].exp_fe));
            check("run_done_pulses", 80'(done_cnt - s_done), 80'(tbl[t].exp_done));
        end

        // Randomized runs: expected results are one per frame, in order,
        // carrying the data supplied for that frame.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 4);
            exp_q.delete();
            for (int i = 0; i < n; i++) exp_q.push_back(RESULT_W'({$urandom(), $urandom()}));
            s_fe = fe_cnt; s_done = done_cnt;
            start_run(n);
            for (int i = 0; i < n; i++)
                do_frame(i, i == n - 1, $urandom_range(0, 30), $urandom_range(1, 10),
                         $urandom_range(0, 5), exp_q[i]);
            done_hold();
            check("rand_fe_pulses", 80'(fe_cnt - s_fe), 80'(n));
            check("rand_done_pulses", 80'(done_cnt - s_done), 80'(1));
        end

        // Watchdog in FEATURE.
        start_run(1);
`ifdef CNN_SEQ_WATCHDOG_EN
        for (int i = 0; i < PROC_TIMEOUT - 1; i++) tick();
        check("wd_not_yet", {result_valid, cnn_busy}, 2'b01);
        tick();
        tc_exp++;
        check("wd_result", {result_valid, result_timeout, result_frame, result_data, timeout_count},
              {1'b1, 1'b1, FRAME_W'(0), RESULT_W'(0), FRAME_W'(tc_exp)});
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("wd_done", {run_done, result_valid}, 2'b10);
        done_hold();
`else
        for (int i = 0; i < PROC_TIMEOUT + 50; i++) tick();
        check("no_wd_stays", {cnn_busy, result_valid, result_timeout, timeout_count},
              {1'b1, 1'b0, 1'b0, FRAME_W'(0)});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("no_wd_abort", {cnn_busy, result_valid}, 2'b00);
`endif

        // FC result coincident with watchdog expiry in WAIT_FC: data wins.
        start_run(1);
        buf_full = 1'b1;
        tick();
        buf_full = 1'b0;
        check("coinc_fc_start", fc_start, 1'b1);
        for (int i = 0; i < PROC_TIMEOUT - 1; i++) tick();
        fc_result_valid = 1'b1;
        fc_result_data  = 48'sh00000ABCDE00;
        tick();
        fc_result_valid = 1'b0;
        check("coinc_result", {result_valid, result_timeout, result_data, timeout_count},
              {1'b1, 1'b0, 48'sh00000ABCDE00, FRAME_W'(tc_exp)});
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        done_hold();

        // Abort in WAIT_FC of frame 1 of 4.
        s_done = done_cnt;
        start_run(4);
        do_frame(0, 1'b0, 5, 2, 0, 48'sh000000000777);
        buf_full = 1'b1;
        tick();
        buf_full = 1'b0;
        check("abort_fc_start", fc_start, 1'b1);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {cnn_busy, result_valid, fe_start, fc_start, run_done}, 5'b0);
        for (int i = 0; i < 5; i++) tick();
        check("abort_no_done", 80'(done_cnt - s_done), 80'(0));
        check("abort_keeps_tc", timeout_count, FRAME_W'(tc_exp));
        start_signal = 1'b1;
        frame_count  = '0;
        tick();
        start_signal = 1'b0;
        check("zero_frames_ignored", {cnn_busy, fe_start}, 2'b00);

        // Reset during OUTPUT.
        start_run(2);
        buf_full = 1'b1;
        tick();
        buf_full        = 1'b0;
        fc_result_valid = 1'b1;
        fc_result_data  = 48'sh000000005555;
        tick();
        fc_result_valid = 1'b0;
        check("pre_reset_output", result_valid, 1'b1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tc_exp = 0;
        check("mid_reset", {fe_start, fc_start, result_valid, result_data, result_frame,
              result_timeout, run_done, cnn_busy, timeout_count}, '0);

        // start_signal during FEATURE has no effect on the run in progress.
        s_fe = fe_cnt; s_done = done_cnt;
        start_run(1);
        start_signal = 1'b1;
        frame_count  = FRAME_W'(7);
        tick();
        tick();
        start_signal = 1'b0;
        check("start_in_feature", {fe_start, cnn_busy}, 2'b01);
        do_frame(0, 1'b1, 3, 2, 0, 48'sh000000000042);
        done_hold();
        check("start_ignored_fe", 80'(fe_cnt - s_fe), 80'(1));
        check("start_ignored_done", 80'(done_cnt - s_done), 80'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
